// File: rtl/alu_pkg.sv
// +-----------------------------------------------------------------------------+
// | alu_pkg : ALU opcode and mul/div operation encodings shared with muldiv_seq |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_ROL = 4'd9
  } alu_ops_t;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_DIV = 2'b01,
    OP_REM = 2'b10,
    OP_RSV = 2'b11
  } muldiv_op_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
// +-----------------------------------------------------------------------------+
// | muldiv_seq : multi-cycle MUL/DIV/REM sequencer driving the shared ALU        |
// | Optional: SIGNED_MULDIV_EN enables signed DIV/REM via req_op[2]              |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  import alu_pkg::*;

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  muldiv_op_t      op;
  logic [XLEN-1:0] acc;    // MUL accumulator / DIV partial remainder
  logic [XLEN-1:0] opa;    // MUL multiplicand / DIV dividend shifting into quotient
  logic [XLEN-1:0] opb;    // MUL multiplier / DIV divisor
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r;

  muldiv_op_t      req_kind;
  logic            accept, early, last, sgn, ge;
  logic [XLEN-1:0] early_val, a_mag, b_mag, sh, q_next, r_next, div_res;

  assign req_kind  = muldiv_op_t'(req_op[1:0]);
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign early     = (req_kind == OP_RSV) || ((req_kind != OP_MUL) && (req_b == '0));
  assign early_val = (req_kind == OP_DIV) ? '1 : (req_kind == OP_REM) ? req_a : '0;
  assign last      = (cnt == CW'(ITERS - 1));

`ifdef SIGNED_MULDIV_EN
  assign sgn = req_op[2] && (req_kind == OP_DIV || req_kind == OP_REM);
`else
  logic unused_sign;
  assign unused_sign = req_op[2];
  assign sgn         = 1'b0;
`endif

  assign a_mag = (sgn && req_a[XLEN-1]) ? -req_a : req_a;
  assign b_mag = (sgn && req_b[XLEN-1]) ? -req_b : req_b;

  // Restoring step: the 33-bit compare covers a partial remainder whose top bit shifted out
  assign sh      = {acc[XLEN-2:0], opa[XLEN-1]};
  assign ge      = ({acc[XLEN-1], sh} >= {1'b0, opb});
  assign q_next  = {opa[XLEN-2:0], ge};
  assign r_next  = ge ? alu_result : sh;
  assign div_res = (op == OP_DIV) ? (neg_q ? -q_next : q_next)
                                  : (neg_r ? -r_next : r_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = early ? S_DONE : S_CALC;
      S_CALC:  if (last) state_n = S_DONE;
      S_DONE:  if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    alu_op = ALU_NOP;
    alu_a  = '0;
    alu_b  = '0;
    if (state == S_CALC) begin
      if (op == OP_MUL) begin
        alu_op = ALU_ADD;
        alu_a  = acc;
        alu_b  = opb[0] ? opa : '0;
      end else begin
        alu_op = ALU_SUB;
        alu_a  = sh;
        alu_b  = opb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      op         <= OP_MUL;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      resp_valid <= (state_n == S_DONE);
      busy       <= (state_n != S_IDLE);
      if (accept) begin
        op    <= req_kind;
        cnt   <= '0;
        acc   <= '0;
        opa   <= a_mag;
        opb   <= b_mag;
        neg_q <= sgn && (req_a[XLEN-1] ^ req_b[XLEN-1]);
        neg_r <= sgn && req_a[XLEN-1];
        if (early) resp_data <= early_val;
      end else if (state == S_CALC) begin
        cnt <= cnt + CW'(1);
        if (op == OP_MUL) begin
          acc <= alu_result;
          opa <= opa << 1;
          opb <= opb >> 1;
          if (last) resp_data <= alu_result;
        end else begin
          acc <= r_next;
          opa <= q_next;
          if (last) resp_data <= div_res;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural ADD/SUB ALU.
`default_nettype none

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  assign alu_result = (alu_op == 4'd1) ? alu_a + alu_b :
                      (alu_op == 4'd2) ? alu_a - alu_b : 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for resp_valid, returning cycles after the accept edge and busy-high samples.
  task automatic wait_resp(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!resp_valid && lat < 100) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bc;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (exp_lat > 0)
      chk({tag, "_aluop"}, 32'(alu_op), (op[1:0] == 2'b00) ? 32'd1 : 32'd2);
    wait_resp(lat, bc);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(bc), 32'(exp_lat + 1));
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_doneAlu"}, 32'(alu_op), 32'd0);
    step();
    chk({tag, "_idle"}, {29'd0, resp_valid, busy, req_ready}, 32'b001);
  endtask

  initial begin
    int lat, bc;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    step(); step();
    chk("rst_flags", {29'd0, resp_valid, busy, req_ready}, 32'b001);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_alu", {28'd0, alu_op}, 32'd0);
    chk("rst_alua", alu_a | alu_b, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("mul_7x6",   3'b000, 32'd7,        32'd6,        32'd42,        32);
    run_op("mul_ffxff", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32);
    run_op("mul_10000", 3'b000, 32'h00010000, 32'h00010000, 32'h00000000,  32);
    run_op("mul_x9",    3'b000, 32'h12345678, 32'd9,        32'hA3D70A38,  32);
    run_op("div_100_7", 3'b001, 32'd100,      32'd7,        32'd14,        32);
    run_op("rem_100_7", 3'b010, 32'd100,      32'd7,        32'd2,         32);
    run_op("div_ff_1",  3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  32);
    run_op("div_big_3", 3'b001, 32'h80000000, 32'd3,        32'h2AAAAAAA,  32);
    run_op("rem_big_3", 3'b010, 32'h80000000, 32'd3,        32'd2,         32);
    run_op("div_5_0",   3'b001, 32'd5,        32'd0,        32'hFFFFFFFF,  0);
    run_op("rem_5_0",   3'b010, 32'd5,        32'd0,        32'd5,         0);
    run_op("op_rsv",    3'b011, 32'd5,        32'd3,        32'd0,         0);
    run_op("mul_sbit",  3'b100, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA,  32);

`ifdef SIGNED_MULDIV_EN
    run_op("sdiv_m7_2",  3'b101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
    run_op("srem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
    run_op("sdiv_7_m2",  3'b101, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    run_op("srem_7_m2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32);
    run_op("sdiv_ovf",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32);
    run_op("srem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32);
    run_op("sdiv_m5_0",  3'b101, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 0);
`else
    run_op("udiv_m7_2",  3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32);
    run_op("urem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'd1,        32);
    run_op("udiv_ovf",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32);
    run_op("urem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32);
`endif

    // Back-pressure: response held, queued request waits for the cycle after handshake
    resp_ready = 1'b0;
    req_op = 3'b000; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    step();
    req_op = 3'b001; req_a = 32'd9; req_b = 32'd3;
    wait_resp(lat, bc);
    chk("bp_lat", 32'(lat), 32'd32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", resp_data, 32'd15);
      chk("bp_hold", {30'd0, resp_valid, req_ready}, 32'b10);
      step();
    end
    resp_ready = 1'b1;
    chk("bp_last", {29'd0, resp_valid, busy, req_ready}, 32'b110);
    step();
    chk("bp_hs", {29'd0, resp_valid, busy, req_ready}, 32'b001);
    step();
    req_valid = 1'b0;
    chk("bp_acc", {30'd0, busy, req_ready}, 32'b10);
    wait_resp(lat, bc);
    chk("bp2_lat", 32'(lat), 32'd32);
    chk("bp2_data", resp_data, 32'd3);
    step();

    // Asynchronous reset in the middle of a divide
    req_op = 3'b001; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flags", {29'd0, resp_valid, busy, req_ready}, 32'b001);
    chk("ar_alu", {28'd0, alu_op}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_norsp", 32'(resp_valid), 32'd0);
    run_op("div_9_3", 3'b001, 32'd9, 32'd3, 32'd3, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle integer multiply/divide sequencer that drives the shared 32-bit ALU through its op/A/B/result interface. One ALU operation per cycle: ADD for shift-add multiply, SUB for restoring divide. Sits beside the ALU in the execute stage and gives the core MUL/DIV/REM without adding a hardware multiplier or divider.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, 32, iterations per MUL/DIV; must equal XLEN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  3  [1:0]: 00 MUL (low 32), 01 DIV, 10 REM, 11 reserved; [2]: signed (see Optional Feature)
req_a  in  32  multiplicand / dividend
req_b  in  32  multiplier / divisor
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  32  result
busy  out  1  state != IDLE
alu_op  out  4  to ALU: 4'b0001 ADD, 4'b0010 SUB, 4'b0000 when not iterating
alu_a  out  32  to ALU A
alu_b  out  32  to ALU B
alu_result  in  32  from ALU, combinational, same cycle

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; busy=0; alu_op=0; alu_a=0; alu_b=0; counter and internal registers cleared. An in-flight operation is dropped with no response.
- FSM has three states: IDLE, CALC, DONE.
- IDLE: handshake on req_valid&&req_ready at edge T latches op/operands, cnt=0.
  - Normal case: go to CALC.
  - DIV with b==0: resp_data=0xFFFFFFFF, go to DONE.
  - REM with b==0: resp_data=a, go to DONE.
  - op 11: resp_data=0, go to DONE.
  - In these three cases resp_valid=1 at T+1.
- CALC: exactly ITERS cycles. cnt increments each cycle; on cnt==ITERS-1, result registers load and state goes to DONE. resp_valid=1 at T+33.
- MUL iteration: alu_op=ADD, alu_a=acc, alu_b = mplr[0] ? mcand : 0. Then acc<=alu_result, mcand<=mcand<<1, mplr<=mplr>>1. Result is acc mod 2^32.
- DIV/REM iteration (restoring): sh = {rem[30:0], dvd[31]}; alu_op=SUB, alu_a=sh, alu_b=divisor.
  - ge = ({rem[31],sh} >= {1'b0,divisor}), a local 33-bit compare.
  - rem <= ge ? alu_result : sh.
  - dvd <= {dvd[30:0], ge}; dvd holds the quotient at the end.
- DONE: resp_valid=1 and resp_data stable until resp_ready. Handshake -> IDLE, resp_valid=0 next cycle. req_ready is 0 in the same cycle, so a new request is accepted no earlier than the cycle after the response handshake.
- alu_op/alu_a/alu_b are 0 in IDLE and DONE. Outputs are registered except alu_* and req_ready, which decode combinationally from state/regs.
- req_valid while busy is ignored; the requester must hold it until req_ready.

Optional Feature:
Macro SIGNED_MULDIV_EN.
- Defined: req_op[2]=1 selects signed DIV/REM. Operands are converted to magnitudes at accept. The quotient is negated if the signs differ; the remainder takes the dividend's sign (negation done locally on result load, no extra cycle). Divide by zero gives the same results as unsigned. 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. MUL is unaffected by req_op[2].
- Undefined: req_op[2] is ignored and all operations are unsigned.

Decomposition:
- Shared package alu_pkg: ALU opcode enum alu_ops_t (ADD..ROL, 4-bit), to be used by both the ALU and this block; muldiv_op_t (2-bit MUL/DIV/REM/RSV); constant XLEN=32.
- No internal sub-module. FSM and datapath registers stay in one module; the ALU is instantiated by the parent and wired to alu_*.

Test Plan:
- MUL 7*6, resp_ready=1 -> resp_data=42 at T+33; alu_op=0001 during CALC; busy=1 for 33 cycles.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MUL 0x10000*0x10000 -> 0x00000000.
- DIV 100/7 -> 14; REM 100/7 -> 2; DIV 0xFFFFFFFF/1 -> 0xFFFFFFFF; all at T+33.
- DIV 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5 at T+1; op 11 -> 0 at T+1.
- Back-pressure: resp_ready=0 for 5 cycles in DONE -> resp_data stable, req_ready=0, second req_valid not accepted until the cycle after the handshake.
- rst_n low at cycle 10 of CALC -> immediately resp_valid=0, req_ready=1, alu_op=0; next DIV 9/3 -> 3. With SIGNED_MULDIV_EN: signed DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
